// File: rtl/band_recorder.sv
// band_recorder: trigger-armed audio capture that streams samples into a BRAM write port
module band_recorder #(
    parameter int MEM_DEPTH  = 4036,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           sample_in,
    input  logic                  sample_valid,
    input  logic                  start,
    input  logic                  stop,
    input  logic [14:0]           trig_level,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [15:0]           wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   sample_count
);
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, RECORD, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d, cnt_inc;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]           wr_data_q, wr_data_d;
    logic [15:0]           neg;
    logic [14:0]           mag;
    logic                  trig, accept;

    always_comb begin
        neg     = -sample_in;
        // only -32768 negates to a value with bit 15 still set; saturate it
        mag     = ~sample_in[15] ? sample_in[14:0] : neg[15] ? 15'h7fff : neg[14:0];
        trig    = mag >= trig_level;
        cnt_inc = cnt_q + 1'b1;
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = ARMED;
                    cnt_d   = '0;
                end
            end
            ARMED: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (sample_valid && trig) begin
                    accept  = 1'b1;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == DEPTH) ? DONE : RECORD;
                end
            end
            RECORD: begin
                if (sample_valid) begin
                    accept = 1'b1;
                    cnt_d  = cnt_inc;
                end
                if (stop || (sample_valid && cnt_inc == DEPTH)) state_d = DONE;
            end
        endcase
        wr_en_d   = accept;
        wr_addr_d = accept ? cnt_q[ADDR_WIDTH-1:0] : wr_addr_q;
        wr_data_d = accept ? sample_in : wr_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign sample_count = cnt_q;
    assign busy         = (state_q == ARMED) || (state_q == RECORD);
    assign done         = state_q == DONE;
endmodule
